// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the HH:MM:SS clock controller: mode encoding,
// default timing parameters and blank_mask bit positions.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam int DEF_DIV       = 50_000_000;
  localparam int DEF_DEB_CYC   = 500_000;
  localparam int DEF_BLINK_DIV = 12_500_000;

  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HOUR = 2;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key to single-cycle press pulse: 2-FF synchronizer,
// stability counter, then registered falling-edge detect on the accepted level.
module key_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_q;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync0   <= 1'b1;
      r_sync1   <= 1'b1;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= key_n;
      r_sync1   <= r_sync0;
      r_level_q <= r_level;
      r_press   <= r_level_q & ~r_level;
      // Any cycle back at the accepted level restarts the stability window.
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for the clock datapath: 1 Hz count enables in RUN,
// two-key field editing in SET modes, and a blink mask for the edited field.
module clock_time_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DEB_CYC   = DEF_DEB_CYC,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       sec_at_max,
  input  logic       min_at_max,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic [1:0] mode,
  output logic [2:0] blank_mask
);

  localparam int PW = $clog2(DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic          w_press_mode;
  logic          w_press_inc;
  logic          w_inc;
  logic          w_tick;
  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic [PW-1:0] r_pre;
  logic [BW-1:0] r_blk_cnt;
  logic          r_phase;
  logic          r_sec_en;
  logic          r_min_en;
  logic          r_hour_en;
  logic [2:0]    w_mask;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_mode (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_mode_n),
    .press    (w_press_mode)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_inc (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_inc_n),
    .press    (w_press_inc)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_mode <= MODE_RUN;
    else       r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press_mode) begin
      case (r_mode)
        MODE_RUN:      w_mode_nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: w_mode_nxt = MODE_SET_MIN;
        MODE_SET_MIN:  w_mode_nxt = MODE_SET_SEC;
        default:       w_mode_nxt = MODE_RUN;
      endcase
    end
  end

  // A mode press in the same cycle swallows the inc press.
  assign w_inc  = w_press_inc & ~w_press_mode;
  assign w_tick = (r_mode == MODE_RUN) && (r_pre == P_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pre     <= '0;
      r_sec_en  <= 1'b0;
      r_min_en  <= 1'b0;
      r_hour_en <= 1'b0;
    end else begin
      if ((w_mode_nxt != MODE_RUN) || (r_mode != MODE_RUN) || w_tick) r_pre <= '0;
      else                                                           r_pre <= r_pre + 1'b1;
      r_sec_en  <= w_tick | (w_inc && (r_mode == MODE_SET_SEC));
      r_min_en  <= (w_tick & sec_at_max) | (w_inc && (r_mode == MODE_SET_MIN));
      r_hour_en <= (w_tick & sec_at_max & min_at_max) | (w_inc && (r_mode == MODE_SET_HOUR));
    end
  end

  // Blink restarts visible on every mode change.
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_press_mode || (r_mode == MODE_RUN)) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (r_blk_cnt == B_LAST) begin
      r_blk_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  always_comb begin
    w_mask = '0;
    case (r_mode)
      MODE_SET_HOUR: w_mask[FIELD_HOUR] = r_phase;
      MODE_SET_MIN:  w_mask[FIELD_MIN]  = r_phase;
      MODE_SET_SEC:  w_mask[FIELD_SEC]  = r_phase;
      default:       w_mask = '0;
    endcase
  end

  assign sec_en     = r_sec_en;
  assign min_en     = r_min_en;
  assign hour_en    = r_hour_en;
  assign mode       = r_mode;
  assign blank_mask = w_mask;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with DIV=10, DEB_CYC=4, BLINK_DIV=3.
module tb_clock_time_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       sec_at_max = 1'b0;
  logic       min_at_max = 1'b0;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic [1:0] mode;
  logic [2:0] blank_mask;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses;

  clock_time_ctrl #(.DIV(10), .DEB_CYC(4), .BLINK_DIV(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .sec_at_max (sec_at_max),
    .min_at_max (min_at_max),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hour_en    (hour_en),
    .mode       (mode),
    .blank_mask (blank_mask)
  );

  // clock/reset block
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_mode_press();
    key_mode_n = 1'b0;
    step(10);
    key_mode_n = 1'b1;
    step(10);
  endtask

  initial begin
    // reset state
    step(2);
    check("rst_mode", mode, 2'd0);
    check("rst_en", {sec_en, min_en, hour_en}, 3'b000);
    check("rst_mask", blank_mask, 3'b000);
    reset = 1'b0;

    // free run, no carries: sec_en after edges 10, 20, 30
    for (int i = 1; i <= 35; i++) begin
      step(1);
      check("run_sec", sec_en, (i % 10 == 0) ? 1'b1 : 1'b0);
      check("run_minhour", {min_en, hour_en}, 2'b00);
      check("run_mask", blank_mask, 3'b000);
    end

    // both carries high through the tick at edge 40
    sec_at_max = 1'b1;
    min_at_max = 1'b1;
    for (int i = 36; i <= 41; i++) begin
      step(1);
      check("carry_all", {sec_en, min_en, hour_en}, (i == 40) ? 3'b111 : 3'b000);
    end
    min_at_max = 1'b0;
    for (int i = 42; i <= 50; i++) begin
      step(1);
      check("carry_sec", {sec_en, min_en, hour_en}, (i == 50) ? 3'b110 : 3'b000);
    end
    sec_at_max = 1'b0;

    // bounce shorter than the debounce window
    key_mode_n = 1'b0;
    step(2);
    key_mode_n = 1'b1;
    step(12);
    check("bounce_mode", mode, 2'd0);

    // clean mode press: RUN -> SET_HOUR 8 cycles after the edge
    key_mode_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k <= 8) check("mode_lat", mode, (k == 8) ? 2'd1 : 2'd0);
    end
    key_mode_n = 1'b1;
    step(12);
    check("mode_once", mode, 2'd1);

    // SET_HOUR -> SET_MIN, blink starts visible, toggles every 3 cycles
    key_mode_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 10) key_mode_n = 1'b1;
      if (k == 7) check("to_min_pre", mode, 2'd1);
      if (k >= 8) begin
        check("to_min", mode, 2'd2);
        check("blink", blank_mask, (((k - 8) / 3) % 2 == 1) ? 3'b010 : 3'b000);
      end
    end

    // two inc presses with minute at 59: one min_en each, no carry
    min_at_max = 1'b1;
    sec_at_max = 1'b1;
    n_pulses = 0;
    for (int p = 0; p < 2; p++) begin
      key_inc_n = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        step(1);
        if (k == 10) key_inc_n = 1'b1;
        if (min_en) n_pulses++;
        check("inc_min", min_en, (k == 8) ? 1'b1 : 1'b0);
        check("inc_other", {sec_en, hour_en}, 2'b00);
      end
    end
    check("inc_count", n_pulses, 2);
    min_at_max = 1'b0;
    sec_at_max = 1'b0;

    // SET_MIN -> SET_SEC, then mode+inc together: mode wins
    do_mode_press();
    check("to_sec", mode, 2'd3);
    key_mode_n = 1'b0;
    key_inc_n  = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (k == 10) begin
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
      end
      check("both_sec", sec_en, (k == 18) ? 1'b1 : 1'b0);
      check("both_other", {min_en, hour_en}, 2'b00);
      check("both_mode", mode, (k >= 8) ? 2'd0 : 2'd3);
      if (k >= 8) check("both_mask", blank_mask, 3'b000);
    end

    // reset mid-debounce of inc while in SET_HOUR
    do_mode_press();
    check("to_hour", mode, 2'd1);
    key_inc_n = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    check("mrst_mode", mode, 2'd0);
    check("mrst_en", {sec_en, min_en, hour_en}, 3'b000);
    check("mrst_mask", blank_mask, 3'b000);
    step(1);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("mrst_press", dut.u_key_inc.press, (k == 7) ? 1'b1 : 1'b0);
      check("mrst_hour", hour_en, 1'b0);
      check("mrst_run", mode, 2'd0);
    end
    key_inc_n = 1'b1;
    step(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
